gs_mix_seq: RTL

- Parametrised, time-multiplexed sample mixer for the General Sound output path.
- Generalises the fixed 4-channel A+B / C+D summing to CH channels, each with its own volume and L/R routing.
- Output is saturating, not wrapping.
- Sits between the gs core channel outputs and the board audio DAC/mixer, in the clk_sys domain.
- Uses one shared multiplier: one channel is processed per clock after a sample strobe.

---
 rtl/gs_mix_pkg.sv | 25 ++
 rtl/gs_mix_sat.sv | 19 +
 rtl/gs_mix_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gs_mix_pkg.sv
// Shared types and width helpers for the gs_mix_seq sample mixer.
// The optional peak-hold feature is enabled in the top by defining GS_MIX_PEAK_EN.
package gs_mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CH_DEF = 4;
    localparam int IW_DEF = 14;
    localparam int VW_DEF = 6;
    localparam int OW_DEF = 15;

    // Wide enough that CH full-scale products at full volume never wrap.
    function automatic int acc_w(input int iw, input int vw, input int ch);
        return iw + vw + $clog2(ch);
    endfunction

    function automatic int idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/gs_mix_sat.sv
// Scales an accumulator back to unity gain (>> VW-1) and clamps it to OW bits.
module gs_mix_sat #(
    parameter int AW = 22,
    parameter int VW = 6,
    parameter int OW = 15
) (
    input  logic [AW-1:0] i_acc,
    output logic [OW-1:0] o_out
);

    localparam int SW = (AW > OW) ? AW : OW;
    localparam logic [SW-1:0] MAX_OUT = SW'({OW{1'b1}});

    logic [SW-1:0] w_shift;

    assign w_shift = SW'(i_acc) >> (VW - 1);
    assign o_out   = (w_shift > MAX_OUT) ? {OW{1'b1}} : w_shift[OW-1:0];

endmodule

// File: rtl/gs_mix_seq.sv
// Time-multiplexed CH-channel volume/pan mixer with saturating L/R outputs.
// Define GS_MIX_PEAK_EN to add peak_clr / peak_l / peak_r peak-hold tracking.
//
// state | meaning
// IDLE  | waiting for stb; outputs hold the last mix
// ACC   | one channel multiplied and accumulated per clock
// DONE  | saturate accumulators into outputs, pulse valid
module gs_mix_seq
    import gs_mix_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int IW = IW_DEF,
    parameter int VW = VW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic             clk_sys,
    input  logic             areset,
    input  logic             stb,
    input  logic [CH*IW-1:0] ch_smp,
    input  logic [CH*VW-1:0] ch_vol,
    input  logic [CH-1:0]    pan_l,
    input  logic [CH-1:0]    pan_r,
`ifdef GS_MIX_PEAK_EN
    input  logic             peak_clr,
    output logic [OW-1:0]    peak_l,
    output logic [OW-1:0]    peak_r,
`endif
    output logic [OW-1:0]    out_l,
    output logic [OW-1:0]    out_r,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int AW = acc_w(IW, VW, CH);
    localparam int XW = idx_w(CH);
    localparam int PW = IW + VW;

    state_t           r_state;
    logic [XW-1:0]    r_idx;
    logic [CH*IW-1:0] r_smp;
    logic [CH*VW-1:0] r_vol;
    logic [CH-1:0]    r_pan_l;
    logic [CH-1:0]    r_pan_r;
    logic [AW-1:0]    r_acc_l;
    logic [AW-1:0]    r_acc_r;
    logic [OW-1:0]    r_out_l;
    logic [OW-1:0]    r_out_r;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    logic [IW-1:0]    w_smp;
    logic [VW-1:0]    w_vol;
    logic [PW-1:0]    w_prod;
    logic [OW-1:0]    w_sat_l;
    logic [OW-1:0]    w_sat_r;

    // Single shared multiplier, fed from the snapshot by the channel index.
    assign w_smp  = r_smp[int'(r_idx)*IW +: IW];
    assign w_vol  = r_vol[int'(r_idx)*VW +: VW];
    assign w_prod = {{VW{1'b0}}, w_smp} * {{IW{1'b0}}, w_vol};

    gs_mix_sat #(.AW(AW), .VW(VW), .OW(OW)) u_sat_l (
        .i_acc (r_acc_l),
        .o_out (w_sat_l)
    );

    gs_mix_sat #(.AW(AW), .VW(VW), .OW(OW)) u_sat_r (
        .i_acc (r_acc_r),
        .o_out (w_sat_r)
    );

    always_ff @(posedge clk_sys or posedge areset) begin
        if (areset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_smp     <= '0;
            r_vol     <= '0;
            r_pan_l   <= '0;
            r_pan_r   <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (stb) begin
                        r_smp   <= ch_smp;
                        r_vol   <= ch_vol;
                        r_pan_l <= pan_l;
                        r_pan_r <= pan_r;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_overrun <= stb;
                    if (r_pan_l[r_idx]) r_acc_l <= r_acc_l + AW'(w_prod);
                    if (r_pan_r[r_idx]) r_acc_r <= r_acc_r + AW'(w_prod);
                    if (r_idx == XW'(CH - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + XW'(1);
                    end
                end
                DONE: begin
                    r_overrun <= stb;
                    r_out_l   <= w_sat_l;
                    r_out_r   <= w_sat_r;
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef GS_MIX_PEAK_EN
    logic [OW-1:0] r_peak_l;
    logic [OW-1:0] r_peak_r;

    // A clear coincident with a new result restarts the peak from that result.
    always_ff @(posedge clk_sys or posedge areset) begin
        if (areset) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (r_state == DONE) begin
            r_peak_l <= (peak_clr || (w_sat_l > r_peak_l)) ? w_sat_l : r_peak_l;
            r_peak_r <= (peak_clr || (w_sat_r > r_peak_r)) ? w_sat_r : r_peak_r;
        end else if (peak_clr) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end
    end

    assign peak_l = r_peak_l;
    assign peak_r = r_peak_r;
`endif

    assign out_l   = r_out_l;
    assign out_r   = r_out_r;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
